// File: rtl/i2c_target_if.sv
// I2C target bus bundle: open-drain pad pair plus the received-byte stream.
interface i2c_target_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_first;
  logic       rx_stop;

  modport slave (input scl_i, sda_i, rx_ready,
                 output sda_oe, rx_data, rx_valid, rx_first, rx_stop);
  modport master(output scl_i, sda_i, rx_ready,
                 input sda_oe, rx_data, rx_valid, rx_first, rx_stop);
endinterface

// File: rtl/i2c_target.sv
// Oversampling I2C target: START/STOP detect, 7-bit address match, write-byte stream.
// Read support (RD_DATA/RD_ACK, tx_* ports) is built only with I2C_TGT_READ_EN.
module i2c_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  i2c_target_if.slave    bus,
  input  logic [6:0]     own_addr,
  output logic           busy,
  output logic           overflow
`ifdef I2C_TGT_READ_EN
  ,
  input  logic [7:0]     tx_data,
  input  logic           tx_valid,
  output logic           tx_ready
`endif
);

`ifdef I2C_TGT_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic ev_rise, ev_fall, ev_start, ev_stop, ev_bit;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // Edge/condition events are registered so every FSM decision sees one aligned snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      ev_rise  <= 1'b0;
      ev_fall  <= 1'b0;
      ev_start <= 1'b0;
      ev_stop  <= 1'b0;
      ev_bit   <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
      ev_rise  <= scl_s & ~scl_d;
      ev_fall  <= ~scl_s & scl_d;
      ev_start <= scl_s & scl_d & sda_d & ~sda_s;
      ev_stop  <= scl_s & scl_d & ~sda_d & sda_s;
      ev_bit   <= sda_s;
    end
  end

  state_t     state;
  logic [3:0] cnt;
  logic [6:0] sr;
  logic       ack_q, ack_ph, first_q;
  logic [7:0] byte_in;
  logic       hold_free;

  assign byte_in   = {sr, ev_bit};
  assign hold_free = !bus.rx_valid || bus.rx_ready;

`ifdef I2C_TGT_READ_EN
  logic       rd_q, m_ack;
  logic [7:0] tx_sr, tx_next;
  assign tx_next = tx_valid ? tx_data : 8'hFF;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      sr           <= '0;
      ack_q        <= 1'b0;
      ack_ph       <= 1'b0;
      first_q      <= 1'b0;
      bus.sda_oe   <= 1'b0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      bus.rx_first <= 1'b0;
      bus.rx_stop  <= 1'b0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
`ifdef I2C_TGT_READ_EN
      rd_q         <= 1'b0;
      m_ack        <= 1'b0;
      tx_sr        <= '0;
      tx_ready     <= 1'b0;
`endif
    end else begin
      bus.rx_stop <= 1'b0;
`ifdef I2C_TGT_READ_EN
      tx_ready    <= 1'b0;
`endif
      if (bus.rx_valid && bus.rx_ready) bus.rx_valid <= 1'b0;

      if (ev_start) begin
        state      <= ADDR;
        cnt        <= '0;
        ack_ph     <= 1'b0;
        bus.sda_oe <= 1'b0;
        busy       <= 1'b0;
        first_q    <= 1'b1;
      end else if (ev_stop) begin
        state       <= IDLE;
        bus.sda_oe  <= 1'b0;
        busy        <= 1'b0;
        bus.rx_stop <= busy;
      end else begin
        case (state)
          ADDR: if (ev_rise) begin
            sr  <= byte_in[6:0];
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt    <= '0;
              ack_ph <= 1'b0;
`ifdef I2C_TGT_READ_EN
              rd_q   <= ev_bit;
`endif
              if (byte_in[7:1] == own_addr && (!ev_bit || READ_EN)) state <= ADDR_ACK;
              else                                                   state <= IGNORE;
            end
          end
          ADDR_ACK: if (ev_fall) begin
            if (!ack_ph) begin
              ack_ph     <= 1'b1;
              bus.sda_oe <= 1'b1;
              busy       <= 1'b1;
`ifdef I2C_TGT_READ_EN
              if (rd_q) begin
                tx_sr    <= tx_next;
                tx_ready <= tx_valid;
              end
`endif
            end else begin
              ack_ph <= 1'b0;
              cnt    <= '0;
`ifdef I2C_TGT_READ_EN
              if (rd_q) begin
                state      <= RD_DATA;
                bus.sda_oe <= ~tx_sr[7];
              end else
`endif
              begin
                state      <= WR_DATA;
                bus.sda_oe <= 1'b0;
              end
            end
          end
          WR_DATA: if (ev_rise) begin
            sr  <= byte_in[6:0];
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt    <= '0;
              ack_ph <= 1'b0;
              ack_q  <= hold_free;
              state  <= WR_ACK;
              // Load wins over a same-cycle handshake clearing rx_valid.
              if (hold_free) begin
                bus.rx_data  <= byte_in;
                bus.rx_valid <= 1'b1;
                bus.rx_first <= first_q;
                first_q      <= 1'b0;
              end else begin
                overflow <= 1'b1;
              end
            end
          end
          WR_ACK: if (ev_fall) begin
            if (!ack_ph) begin
              ack_ph     <= 1'b1;
              bus.sda_oe <= ack_q;
            end else begin
              ack_ph     <= 1'b0;
              bus.sda_oe <= 1'b0;
              state      <= WR_DATA;
            end
          end
`ifdef I2C_TGT_READ_EN
          RD_DATA: begin
            if (ev_rise) cnt <= cnt + 4'd1;
            if (ev_fall) begin
              if (cnt == 4'd8) begin
                bus.sda_oe <= 1'b0;
                state      <= RD_ACK;
              end else begin
                bus.sda_oe <= ~tx_sr[~cnt[2:0]];
              end
            end
          end
          RD_ACK: begin
            if (ev_rise) m_ack <= ~ev_bit;
            if (ev_fall) begin
              if (m_ack) begin
                tx_sr      <= tx_next;
                tx_ready   <= tx_valid;
                bus.sda_oe <= ~tx_next[7];
                cnt        <= '0;
                state      <= RD_DATA;
              end else begin
                state <= IGNORE;
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Randomized bench for i2c_target: bit-banged I2C master, transaction-level model, rx scoreboard.
module tb_i2c_target;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_target_if bus();
  logic [6:0] own_addr;
  logic       busy, overflow;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  assign bus.scl_i = m_scl;
  assign bus.sda_i = m_sda & ~bus.sda_oe;

`ifdef I2C_TGT_READ_EN
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  int         txr_cnt = 0;
`endif

  i2c_target #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .own_addr(own_addr),
    .busy(busy), .overflow(overflow)
`ifdef I2C_TGT_READ_EN
    , .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
`endif
  );

  typedef struct packed { logic [7:0] d; logic f; } rx_t;

  int         checks = 0, errors = 0;
  rx_t        sb[$];
  int         stop_cnt = 0, stop_exp = 0, oe_hits = 0;
  bit         quiet = 0, held = 0, exp_ovf = 0;
  logic [7:0] held_data = 8'h00;
  logic [7:0] dbuf [0:7];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted byte, counts stop pulses and stray drive.
  always @(negedge clk) begin
    rx_t e;
    if (!rst) begin
      if (bus.rx_valid && bus.rx_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got byte %0h expected none", bus.rx_data);
        end else begin
          e = sb.pop_front();
          chk("rx_data", {24'h0, bus.rx_data}, {24'h0, e.d});
          chk("rx_first", {31'h0, bus.rx_first}, {31'h0, e.f});
        end
      end
      if (bus.rx_stop) stop_cnt++;
      if (quiet && bus.sda_oe) oe_hits++;
`ifdef I2C_TGT_READ_EN
      if (tx_ready) txr_cnt++;
`endif
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    if (!m_scl) begin
      wait_cyc(2); m_sda = 1'b1; wait_cyc(H-2); m_scl = 1'b1; wait_cyc(H);
    end
    m_sda = 1'b0; wait_cyc(H); m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_cyc(2); m_sda = 1'b0; wait_cyc(H-2); m_scl = 1'b1; wait_cyc(H);
    m_sda = 1'b1; wait_cyc(H);
  endtask

  task automatic write_bit(input logic b);
    wait_cyc(2); m_sda = b; wait_cyc(H-2);
    m_scl = 1'b1; wait_cyc(H); m_scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wait_cyc(2); m_sda = 1'b1; wait_cyc(H-2);
    m_scl = 1'b1; wait_cyc(H/2); b = bus.sda_i; wait_cyc(H/2); m_scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  // Reference: target ACKs its own write address; a byte is ACKed unless one is still held.
  task automatic run_seg(input logic [6:0] a, input logic rw, input int n, input int off,
                         input bit rdy, output bit addressed);
    logic ack;
    bit   ea, eack;
    rx_t  e;
    i2c_start();
    ea = (a == own_addr) && !rw;
    write_byte({a, rw}, ack);
    chk("addr_ack", {31'h0, ack}, {31'h0, !ea});
    if (ea) chk("busy_on", {31'h0, busy}, 32'h1);
    for (int i = 0; i < n; i++) begin
      eack = ea && (rdy || !held);
      if (eack) begin
        e.d = dbuf[off+i];
        e.f = (i == 0);
        sb.push_back(e);
        if (!rdy) begin held = 1; held_data = dbuf[off+i]; end
      end else if (ea) begin
        exp_ovf = 1;
      end
      write_byte(dbuf[off+i], ack);
      chk("data_ack", {31'h0, ack}, {31'h0, !eack});
    end
    addressed = ea;
  endtask

  task automatic run_txn(input logic [6:0] a1, input logic rw1, input int n1, input bit rs,
                         input logic [6:0] a2, input int n2, input bit rdy);
    bit ad1, ad2;
    int k;
    bus.rx_ready = rdy;
    run_seg(a1, rw1, n1, 0, rdy, ad1);
    ad2 = ad1;
    if (rs) run_seg(a2, 1'b0, n2, n1, rdy, ad2);
    i2c_stop();
    wait_cyc(12);
    if (ad2) stop_exp++;
    chk("rx_stop_count", stop_cnt, stop_exp);
    chk("busy_idle", {31'h0, busy}, 32'h0);
    chk("overflow", {31'h0, overflow}, {31'h0, exp_ovf});
    if (held) begin
      chk("held_data", {24'h0, bus.rx_data}, {24'h0, held_data});
      chk("held_valid", {31'h0, bus.rx_valid}, 32'h1);
    end
    bus.rx_ready = 1'b1;
    k = 0;
    while (sb.size() != 0 && k < 200) begin wait_cyc(1); k++; end
    chk("drain", sb.size(), 0);
    held = 0;
    wait_cyc(20);
  endtask

  task automatic chk_reset_vals();
    chk("rst_sda_oe", {31'h0, bus.sda_oe}, 32'h0);
    chk("rst_rx_data", {24'h0, bus.rx_data}, 32'h0);
    chk("rst_rx_valid", {31'h0, bus.rx_valid}, 32'h0);
    chk("rst_rx_first", {31'h0, bus.rx_first}, 32'h0);
    chk("rst_rx_stop", {31'h0, bus.rx_stop}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
  endtask

  initial begin
    int   k;
    int   n1, n2;
    bit   rs;
    logic [6:0] a1, a2;
`ifdef I2C_TGT_READ_EN
    logic       ack;
    logic [7:0] rd;
    logic       b;
    tx_data  = 8'hCD;
    tx_valid = 1'b1;
`endif
    bus.rx_ready = 1'b1;
    own_addr     = 7'h50;
    wait_cyc(4);
    chk_reset_vals();
    rst = 1'b0;
    wait_cyc(10);

    dbuf[0] = 8'hAB;
    run_txn(7'h50, 1'b0, 1, 0, 7'h00, 0, 1);

    oe_hits = 0; quiet = 1;
    dbuf[0] = 8'h3C;
    run_txn(7'h51, 1'b0, 1, 0, 7'h00, 0, 1);
    quiet = 0;
    chk("no_drive_other_addr", oe_hits, 0);

    dbuf[0] = 8'h11; dbuf[1] = 8'h22;
    run_txn(7'h50, 1'b0, 2, 0, 7'h00, 0, 0);

    dbuf[0] = 8'h01; dbuf[1] = 8'h02;
    run_txn(7'h50, 1'b0, 1, 1, 7'h50, 1, 1);

`ifndef I2C_TGT_READ_EN
    dbuf[0] = 8'h77;
    run_txn(7'h50, 1'b1, 1, 0, 7'h00, 0, 1);
`endif

    for (int t = 0; t < 10; t++) begin
      own_addr = 7'($urandom);
      a1 = ($urandom_range(0, 3) != 0) ? own_addr : 7'($urandom);
      a2 = ($urandom_range(0, 3) != 0) ? own_addr : 7'($urandom);
      n1 = $urandom_range(1, 3);
      n2 = $urandom_range(1, 3);
      rs = $urandom_range(0, 1);
      for (int i = 0; i < 8; i++) dbuf[i] = 8'($urandom);
      run_txn(a1, 1'b0, n1, rs, a2, n2, bit'($urandom_range(0, 1)));
    end

`ifdef I2C_TGT_READ_EN
    own_addr = 7'h50;
    txr_cnt  = 0;
    i2c_start();
    write_byte({7'h50, 1'b1}, ack);
    chk("rd_addr_ack", {31'h0, ack}, 32'h0);
    rd = 8'h00;
    for (int i = 7; i >= 0; i--) begin read_bit(b); rd[i] = b; end
    write_bit(1'b1);
    chk("rd_data", {24'h0, rd}, 32'hCD);
    oe_hits = 0; quiet = 1;
    wait_cyc(10);
    i2c_stop();
    wait_cyc(12);
    quiet = 0;
    stop_exp++;
    chk("rd_ignore_quiet", oe_hits, 0);
    chk("tx_ready_pulses", txr_cnt, 1);
    chk("rd_stop_count", stop_cnt, stop_exp);
    wait_cyc(20);
`endif

    // Reset in the middle of an address ACK.
    own_addr = 7'h50;
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(k_bit(8'hA0, i));
    k = 0;
    while (!bus.sda_oe && k < 50) begin wait_cyc(1); k++; end
    chk("ack_before_rst", {31'h0, bus.sda_oe}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("sda_oe_released", {31'h0, bus.sda_oe}, 32'h0);
    wait_cyc(2);
    chk_reset_vals();
    rst = 1'b0;
    exp_ovf = 0;
    wait_cyc(5);
    i2c_stop();
    wait_cyc(20);
    dbuf[0] = 8'h5A;
    run_txn(7'h50, 1'b0, 1, 0, 7'h00, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic logic k_bit(input logic [7:0] v, input int i);
    return v[i];
  endfunction

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/i2c_target.md
# i2c_target

Synchronous I2C target (slave) front-end that sits on the far side of the `i2c_ip` master's open-drain SCL/SDA pair and consumes what that master produces. It oversamples SCL/SDA in the system clock domain and detects START, repeated START and STOP. It matches a 7-bit address, ACKs/NACKs, and delivers received write bytes on a valid/ready stream. It is the synthesizable replacement for the behavioural ACK model used in I2C benches and the receive end of board loopback tests.

## Interface
- `SYNC_STAGES`, 2: flip-flop synchronizer depth on `scl_i`/`sda_i` (minimum 2).
- `clk` input 1: system clock (100 MHz nominal); all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `scl_i` input 1: raw SCL level from pad (pulled up).
- `sda_i` input 1: raw SDA level from pad (pulled up).
- `sda_oe` output 1: 1 drives SDA low; 0 releases (tri-state at top level); never drives high.
- `own_addr` input 7: target address; sampled at each address byte's 8th SCL rise.
- `rx_data` output 8: received write byte.
- `rx_valid` output 1: `rx_data` holds an unconsumed byte.
- `rx_ready` input 1: consumer accepts byte when `rx_valid && rx_ready`.
- `rx_first` output 1: qualifies `rx_data`; byte is first after a START/repeated START.
- `rx_stop` output 1: one-cycle pulse on STOP ending an addressed transaction.
- `busy` output 1: addressed transaction in progress (between matching address ACK and STOP/restart).
- `overflow` output 1: sticky; set when a byte was NACKed because the holding register was full; cleared only by `rst`.
- With `I2C_TGT_READ_EN` only: `tx_data` input 8, `tx_valid` input 1, `tx_ready` output 1 (one-cycle pulse when `tx_data` is latched for transmission).

## Operation
- Synchronize `scl_i`/`sda_i` through `SYNC_STAGES` FFs, plus one extra register for edge detection; all decisions use synchronized values.
- START: SDA 1->0 while SCL high. STOP: SDA 0->1 while SCL high. Both are recognised in every state.
- START (including repeated) -> ADDR, bit counter = 0, `sda_oe` = 0.
- STOP -> IDLE, `sda_oe` = 0; pulses `rx_stop` if `busy` was 1.
- Data bits are sampled on synchronized SCL rise, MSB first. `sda_oe` changes only on synchronized SCL fall.
- States:
  - IDLE
  - ADDR: 8 bits.
  - ADDR_ACK: if addr==`own_addr` and R/W=0 -> ACK, then WR_DATA; if R/W=1, see Configuration; else IGNORE.
  - WR_DATA: 8 bits.
  - WR_ACK: ACK if holding register empty, or emptied by a handshake at the 8th rise; else NACK and set `overflow`; then WR_DATA.
  - RD_DATA, RD_ACK (macro only).
  - IGNORE: no drive until START/STOP.
- ACK timing: `sda_oe`=1 from SCL fall after bit 8 until the next SCL fall (9th clock).
- A byte loads `rx_data`/`rx_valid`/`rx_first` at the 8th SCL rise, only if it will be ACKed. A NACKed byte is dropped.
- `rx_valid` clears on handshake; load has priority when handshake and load coincide in the same cycle.

## Timing
- Reset values: `sda_oe`=0, `rx_data`=0, `rx_valid`=0, `rx_first`=0, `rx_stop`=0, `busy`=0, `overflow`=0, `tx_ready`=0; state IDLE.
- Reset mid-transfer releases SDA on the next clock edge.
- Latency from pad edge to internal edge event: `SYNC_STAGES`+1 cycles.
- `rx_valid` rises `SYNC_STAGES`+2 cycles after the pad SCL rise of bit 8.
- SCL high and low phases must each be ≥ `SYNC_STAGES`+3 clk cycles; SDA changes at least 1 clk after SCL fall. Behaviour outside these limits is undefined.
- START and STOP override any in-progress bit or ACK in the same cycle.

## Configuration
- `I2C_TGT_READ_EN` defined:
  - R/W=1 with address match -> ACK, then RD_DATA. `tx_data` is latched at the ACK SCL fall if `tx_valid`, else 0xFF; `tx_ready` pulses on latch.
  - Bits are driven MSB-first on SCL falls (`sda_oe` = ~bit).
  - RD_ACK samples the master's ACK: ACK -> next byte; NACK -> IGNORE.
- Not defined: address match with R/W=1 is NACKed and the block goes to IGNORE. `tx_*` ports are absent.

## Test plan
- `own_addr`=0x50; master writes addr 0x50+W, data 0xAB, STOP -> ACK on both 9th clocks; `rx_data`=0xAB with `rx_first`=1; `rx_stop` pulses once; `busy` 1->0.
- Master addresses 0x51 -> `sda_oe` stays 0 for whole transfer; no `rx_valid`; no `rx_stop`.
- `rx_ready`=0; write 0x11, 0x22 -> 0x11 ACKed and held; 0x22 NACKed; `overflow`=1; `rx_data` stays 0x11.
- Write 0x01, repeated START, write 0x02 -> both bytes delivered with `rx_first`=1; single `rx_stop` at final STOP.
- Assert `rst` while `sda_oe`=1 during ACK -> `sda_oe`=0 next cycle; all outputs at reset values; next START parses normally.
- With `I2C_TGT_READ_EN`, `tx_data`=0xCD valid; master reads one byte then NACK -> SDA carries 0xCD; `tx_ready` pulses once; state IGNORE until STOP.
